// File: rtl/riscv_pkg.sv
// Shared RV32I constants, instruction field positions and the fetch FSM state type.
package riscv_pkg;
  localparam int XLEN     = 32;
  localparam int OPCODE_W = 7;
  localparam int REG_W    = 5;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  typedef enum logic [1:0] {START, WAIT, HELD, DROP} fetch_state_t;
endpackage

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, keeps one imem request outstanding, drives IF/ID.
// Optional perf counters are built when FETCH_PERF_COUNTERS_EN is defined.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_rvalid,
  input  logic [XLEN-1:0]     imem_rdata,
  output logic                if_id_valid,
  output logic [XLEN-1:0]     if_id_pc,
  output logic [XLEN-1:0]     if_id_instruction,
  output logic [OPCODE_W-1:0] if_id_opcode,
  output logic [REG_W-1:0]    if_id_read_reg1,
  output logic [REG_W-1:0]    if_id_read_reg2,
  output logic [XLEN-1:0]     perf_stall_cycles,
  output logic [XLEN-1:0]     perf_flush_count
);

  fetch_state_t    r_state, w_state_n;
  logic [XLEN-1:0] r_pc, w_pc_n;
  logic [XLEN-1:0] r_req_addr, w_req_n;
  logic            r_buf_valid, w_buf_valid_n;
  logic [XLEN-1:0] r_buf_data, w_buf_data_n;
  logic [XLEN-1:0] r_buf_pc, w_buf_pc_n;
  logic            r_ifid_valid, w_ifid_valid_n;
  logic [XLEN-1:0] r_ifid_pc, w_ifid_pc_n;
  logic [XLEN-1:0] r_ifid_instr, w_ifid_instr_n;
  logic [XLEN-1:0] w_redir_pc;

  // Targets are word aligned; misaligned low bits are simply dropped.
  assign w_redir_pc = redirect_pc & ~32'h3;

  // Next-state and next-register computation; redirect outranks stall and fetch.
  always_comb begin
    w_state_n      = r_state;
    w_pc_n         = r_pc;
    w_req_n        = r_req_addr;
    w_buf_valid_n  = r_buf_valid;
    w_buf_data_n   = r_buf_data;
    w_buf_pc_n     = r_buf_pc;
    w_ifid_valid_n = r_ifid_valid;
    w_ifid_pc_n    = r_ifid_pc;
    w_ifid_instr_n = r_ifid_instr;
    if (redirect) begin
      w_ifid_valid_n = 1'b0;
      w_ifid_instr_n = NOP_INSTR;
      w_buf_valid_n  = 1'b0;
      w_pc_n         = w_redir_pc;
      unique case (r_state)
        WAIT: begin
          // Without a response the old request must still be held to completion.
          if (imem_rvalid) w_req_n = w_redir_pc;
          else             w_state_n = DROP;
        end
        START, HELD: begin
          w_req_n   = w_redir_pc;
          w_state_n = WAIT;
        end
        default: ;  // DROP keeps draining the stale request
      endcase
    end else begin
      unique case (r_state)
        START: begin
          w_req_n   = r_pc;
          w_state_n = WAIT;
        end
        WAIT: begin
          if (imem_rvalid && !stall) begin
            w_ifid_valid_n = 1'b1;
            w_ifid_pc_n    = r_req_addr;
            w_ifid_instr_n = imem_rdata;
            w_pc_n         = r_req_addr + 32'd4;
            w_req_n        = r_req_addr + 32'd4;
          end else if (imem_rvalid) begin
            w_buf_valid_n = 1'b1;
            w_buf_data_n  = imem_rdata;
            w_buf_pc_n    = r_req_addr;
            w_state_n     = HELD;
          end else if (!stall) begin
            w_ifid_valid_n = 1'b0;
            w_ifid_instr_n = NOP_INSTR;
          end
        end
        HELD: begin
          if (!stall) begin
            w_ifid_valid_n = r_buf_valid;
            w_ifid_pc_n    = r_buf_pc;
            w_ifid_instr_n = r_buf_data;
            w_buf_valid_n  = 1'b0;
            w_pc_n         = r_buf_pc + 32'd4;
            w_req_n        = r_buf_pc + 32'd4;
            w_state_n      = WAIT;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            w_req_n   = r_pc;
            w_state_n = WAIT;
          end
        end
        default: w_state_n = START;
      endcase
    end
  end

  // State, PC, holding buffer and IF/ID registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= START;
      r_pc         <= PC_RESET;
      r_req_addr   <= PC_RESET;
      r_buf_valid  <= 1'b0;
      r_buf_data   <= NOP_INSTR;
      r_buf_pc     <= '0;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP_INSTR;
    end else begin
      r_state      <= w_state_n;
      r_pc         <= w_pc_n;
      r_req_addr   <= w_req_n;
      r_buf_valid  <= w_buf_valid_n;
      r_buf_data   <= w_buf_data_n;
      r_buf_pc     <= w_buf_pc_n;
      r_ifid_valid <= w_ifid_valid_n;
      r_ifid_pc    <= w_ifid_pc_n;
      r_ifid_instr <= w_ifid_instr_n;
    end
  end

  assign imem_req          = (r_state == WAIT) || (r_state == DROP);
  assign imem_addr         = r_req_addr;
  assign if_id_valid       = r_ifid_valid;
  assign if_id_pc          = r_ifid_pc;
  assign if_id_instruction = r_ifid_instr;
  assign if_id_opcode      = r_ifid_instr[OPC_MSB:OPC_LSB];
  assign if_id_read_reg1   = r_ifid_instr[RS1_MSB:RS1_LSB];
  assign if_id_read_reg2   = r_ifid_instr[RS2_MSB:RS2_LSB];

`ifdef FETCH_PERF_COUNTERS_EN
  logic [XLEN-1:0] r_perf_stall, r_perf_flush;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (stall)    r_perf_stall <= r_perf_stall + 32'd1;
      if (redirect) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_flush_count  = r_perf_flush;
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_count  = '0;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline.
- Owns the PC and issues instruction-memory requests, with at most one request outstanding.
- Drives the IF/ID pipeline register, whose opcode and rs1/rs2 fields feed control_interlock.
- Consumes control_interlock's stall and EXE's branch/jump redirect; absorbs late memory responses during stalls and flushes.

Parameters:
- PC_RESET, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  from control_interlock; hold IF/ID and PC.
- redirect  in  1  taken branch/jump from EXE.
- redirect_pc  in  32  redirect target.
- imem_req  out  1  request valid; held until imem_rvalid.
- imem_addr  out  32  request address; stable while imem_req=1.
- imem_rvalid  in  1  response valid, one per request, at least 1 cycle after req.
- imem_rdata  in  32  instruction word.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  32  PC of IF/ID instruction.
- if_id_instruction  out  32  IF/ID instruction word.
- if_id_opcode  out  7  if_id_instruction[6:0].
- if_id_read_reg1  out  5  if_id_instruction[19:15].
- if_id_read_reg2  out  5  if_id_instruction[24:20].
- perf_stall_cycles  out  32  stall-cycle counter (optional feature).
- perf_flush_count  out  32  redirect counter (optional feature).

Behaviour:
- Reset (reset=0 at clock edge), same cycle:
  - pc=PC_RESET; state=START; imem_req=0; if_id_valid=0.
  - if_id_instruction=NOP_INSTR, so opcode=7'h13 and rs1=rs2=0; if_id_pc=0.
  - Holding buffer cleared; perf counters=0.
- States:
  - START: one idle cycle, imem_rvalid ignored. Next state WAIT; req_addr<=pc.
  - WAIT: imem_req=1, imem_addr=req_addr.
    - rvalid & !stall: IF/ID<=rdata with pc=req_addr, valid=1; pc,req_addr<=req_addr+4; stay WAIT. Back-to-back requests, 1 instr/cycle max.
    - rvalid & stall: rdata,req_addr captured in holding buffer; IF/ID unchanged; -> HELD.
    - !rvalid & stall: IF/ID unchanged.
    - !rvalid & !stall: IF/ID<=bubble (valid=0, NOP_INSTR).
  - HELD: imem_req=0.
    - stall: hold.
    - !stall: IF/ID<=buffer; pc,req_addr<=buffer_pc+4; -> WAIT.
  - DROP: imem_req=1 with old req_addr (protocol requires holding).
    - rvalid: data discarded; req_addr<=pc; -> WAIT.
- Redirect has priority over stall and fetch, in any state:
  - IF/ID<=bubble; buffer invalidated; pc<={redirect_pc[31:2],2'b00} (misaligned low bits forced to 0).
  - From WAIT with !rvalid: -> DROP.
  - From WAIT with rvalid in the same cycle: response discarded; req_addr<=new pc; -> WAIT.
  - From START/HELD: -> WAIT with new pc.
  - From DROP: pc updated; stay DROP.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- IF/ID fields are registered outputs; opcode/rs fields are always slices of if_id_instruction, including bubbles.
- Reset mid-operation (any state, including an outstanding request): fully reinitialised; a response arriving in START is dropped.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- Defined:
  - perf_stall_cycles increments every cycle with stall=1 and reset=1.
  - perf_flush_count increments per cycle with redirect=1.
  - Both wrap at 2^32.
- Undefined: both ports tied to 32'h0; no counter flops.

Decomposition:
- riscv_pkg:
  - NOP_INSTR constant; OPCODE_W=7, REG_W=5, XLEN=32.
  - Field bit positions (opcode [6:0], rs1 [19:15], rs2 [24:20]).
  - fetch_state_t enum {START, WAIT, HELD, DROP}.
- No sub-module: holding buffer and field slicing are inline.

Test Plan:
- Reset then rvalid every cycle (0-cycle wait): if_id_pc sequence 0,4,8,C; if_id_valid=1 from the 3rd cycle after reset release; imem_addr increments each response.
- stall=1 for 3 cycles while rdata=32'h0020_8133 arrives: IF/ID holds prior instr; state HELD; imem_req=0. On stall release, IF/ID shows 0x00208133 with opcode 7'h33, rs1=1, rs2=2; next imem_addr=pc+4.
- redirect=1, redirect_pc=32'h0000_0103 while a request is outstanding: if_id_valid=0 next cycle; the late response is discarded; next request addr=32'h0000_0100.
- redirect and stall asserted together: redirect wins; bubble in IF/ID; fetch resumes at the target after the old response drains.
- Wrap: PC_RESET=32'hFFFF_FFFC -> second imem_addr=32'h0; FETCH_PERF_COUNTERS_EN build: 5 stall cycles + 2 redirects -> counters 5 and 2.
- reset=0 asserted in DROP: outputs return to reset values next edge; a response arriving in START is not loaded into IF/ID.
